// File: rtl/vocab_arb_pkg.sv
// Shared types and helpers for the vocab SRAM port arbiter and its pickers.
package vocab_arb_pkg;

  // Arbiter FSM states
  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  localparam int unsigned MAX_NUM_REQ = 8;

  // Width of a requester index; never narrower than one bit
  function automatic int unsigned owner_width(input int unsigned n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after last_owner, wrapping.
module rr_pick
  import vocab_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned OW      = owner_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OW-1:0]      last_owner,
  output logic [NUM_REQ-1:0] pick,
  output logic [OW-1:0]      pick_idx,
  output logic               any
);

  // Search last_owner+1 .. last_owner+NUM_REQ (mod NUM_REQ); first hit wins
  always_comb begin : search
    int            idx;
    logic [OW-1:0] sel;
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    idx      = 0;
    sel      = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      idx = (int'(last_owner) + k) % int'(NUM_REQ);
      sel = OW'(idx);
      if (!any && req[sel]) begin
        any       = 1'b1;
        pick_idx  = sel;
        pick[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vocab_port_arbiter.sv
// Round-robin arbiter sharing one read-only vocab SRAM port among word matchers.
// A locked grant lets one matcher walk a whole null-terminated entry.
// Optional feature macro: VOCAB_PORT_ARBITER_BURST_LIMIT_EN caps each grant
// at MAX_BURST beats.
module vocab_port_arbiter
  import vocab_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          sram_cs,
  output logic [ADDR_WIDTH-1:0]         sram_addr,
  input  logic [DATA_WIDTH-1:0]         sram_dout
);

  localparam int unsigned OW = owner_width(NUM_REQ);
  localparam logic [OW-1:0] LAST_OWNER_RST = OW'(NUM_REQ - 1);

  // Elaboration-time parameter sanity
  if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ) begin : g_bad_num_req
    $error("vocab_port_arbiter: NUM_REQ must be within 2..%0d", MAX_NUM_REQ);
  end
  if (MAX_BURST < 1) begin : g_bad_max_burst
    $error("vocab_port_arbiter: MAX_BURST must be at least 1");
  end

  arb_state_e           state_q, state_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        last_owner_q, last_owner_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 pend_q, pend_d;
  logic [OW-1:0]        pend_tag_q, pend_tag_d;

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [NUM_REQ-1:0]    pick_oh;
  logic [OW-1:0]         pick_idx;
  logic                  pick_any;
  logic                  owner_req;
  logic                  owner_lock;
  logic [ADDR_WIDTH-1:0] owner_addr;
  logic                  beat;
  logic                  limit_hit;

  // Unpack the flat per-requester address bus
  for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_addr
    assign addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .OW      (OW)
  ) u_rr_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .pick       (pick_oh),
    .pick_idx   (pick_idx),
    .any        (pick_any)
  );

  assign owner_req  = req[owner_q];
  assign owner_lock = lock[owner_q];
  assign owner_addr = addr_arr[owner_q];
  assign beat       = (state_q == ARB_OWNED) && owner_req;

`ifdef VOCAB_PORT_ARBITER_BURST_LIMIT_EN
  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;

  // This beat is the MAX_BURST-th of the grant
  assign limit_hit = (beat_cnt_q == BW'(MAX_BURST - 1));
`else
  assign limit_hit = 1'b0;
`endif

  // Next-state: arbitration in IDLE, beats and release in OWNED
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    gnt_d        = gnt_q;
    pend_d       = 1'b0;
    pend_tag_d   = pend_tag_q;
`ifdef VOCAB_PORT_ARBITER_BURST_LIMIT_EN
    beat_cnt_d   = beat_cnt_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d = ARB_OWNED;
          owner_d = pick_idx;
          gnt_d   = pick_oh;
`ifdef VOCAB_PORT_ARBITER_BURST_LIMIT_EN
          beat_cnt_d = '0;
`endif
        end
      end
      ARB_OWNED: begin
        if (!owner_req) begin
          // Owner withdrew: release without an access
          state_d      = ARB_IDLE;
          gnt_d        = '0;
          last_owner_d = owner_q;
        end else begin
          pend_d     = 1'b1;
          pend_tag_d = owner_q;
`ifdef VOCAB_PORT_ARBITER_BURST_LIMIT_EN
          beat_cnt_d = beat_cnt_q + BW'(1);
`endif
          if (!owner_lock || limit_hit) begin
            state_d      = ARB_IDLE;
            gnt_d        = '0;
            last_owner_d = owner_q;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= '0;
      last_owner_q <= LAST_OWNER_RST;
      gnt_q        <= '0;
      pend_q       <= 1'b0;
      pend_tag_q   <= '0;
`ifdef VOCAB_PORT_ARBITER_BURST_LIMIT_EN
      beat_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      gnt_q        <= gnt_d;
      pend_q       <= pend_d;
      pend_tag_q   <= pend_tag_d;
`ifdef VOCAB_PORT_ARBITER_BURST_LIMIT_EN
      beat_cnt_q   <= beat_cnt_d;
`endif
    end
  end

  // Read-valid tag decode; a reset cycle kills the in-flight read
  always_comb begin
    rd_valid = '0;
    if (pend_q && !rst) begin
      rd_valid[pend_tag_q] = 1'b1;
    end
  end

  assign gnt       = gnt_q;
  assign rd_data   = sram_dout;
  assign sram_cs   = beat && !rst;
  assign sram_addr = sram_cs ? owner_addr : '0;

endmodule

// File: tb/tb_vocab_port_arbiter.sv
// Self-checking bench for vocab_port_arbiter: directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_vocab_port_arbiter;

  localparam int N  = 2;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, lock;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    gnt, rd_valid;
  logic [DW-1:0]   rd_data;
  logic [DW-1:0]   sram_dout = '0;
  logic            sram_cs;
  logic [AW-1:0]   sram_addr;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  logic [DW-1:0] mem [16];

  always #5 clk = ~clk;

  vocab_port_arbiter #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .lock      (lock),
    .req_addr  (req_addr),
    .gnt       (gnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .sram_cs   (sram_cs),
    .sram_addr (sram_addr),
    .sram_dout (sram_dout)
  );

  // Registered-output SRAM
  always @(posedge clk) if (sram_cs) sram_dout <= mem[sram_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit            m_owned     = 1'b0;
  int            m_owner     = 0;
  int            m_last      = N - 1;
  int            m_pend      = -1;
  int            m_cnt       = 0;
  logic [AW-1:0] m_pend_addr = '0;

  function automatic logic [AW-1:0] addr_of(input int i);
    return req_addr[i*AW +: AW];
  endfunction

  function automatic bit limit_reached(input int c);
`ifdef VOCAB_PORT_ARBITER_BURST_LIMIT_EN
    return c >= MB;
`else
    return c < 0;
`endif
  endfunction

  always @(posedge clk) begin : model
    int  np;
    bit  found;
    np    = -1;
    found = 1'b0;
    if (rst) begin
      m_owned = 1'b0;
      m_last  = N - 1;
      m_cnt   = 0;
    end else if (!m_owned) begin
      for (int k = 1; k <= N; k++) begin
        if (!found && req[(m_last + k) % N]) begin
          found   = 1'b1;
          m_owned = 1'b1;
          m_owner = (m_last + k) % N;
          m_cnt   = 0;
        end
      end
    end else if (req[m_owner]) begin
      np          = m_owner;
      m_pend_addr = addr_of(m_owner);
      m_cnt       = m_cnt + 1;
      if (!lock[m_owner] || limit_reached(m_cnt)) begin
        m_owned = 1'b0;
        m_last  = m_owner;
      end
    end else begin
      m_owned = 1'b0;
      m_last  = m_owner;
    end
    m_pend = rst ? -1 : np;
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin : compare
    logic [N-1:0]  e_gnt, e_rv;
    logic          e_cs;
    logic [AW-1:0] e_addr;
    if (chk_en) begin
      e_gnt = '0;
      e_rv  = '0;
      if (m_owned) e_gnt[m_owner] = 1'b1;
      if (m_pend >= 0 && !rst) e_rv[m_pend] = 1'b1;
      e_cs   = m_owned && req[m_owner] && !rst;
      e_addr = e_cs ? addr_of(m_owner) : '0;
      chk("model_gnt", 32'(gnt), 32'(e_gnt));
      chk("model_rd_valid", 32'(rd_valid), 32'(e_rv));
      chk("model_sram_cs", 32'(sram_cs), 32'(e_cs));
      chk("model_sram_addr", 32'(sram_addr), 32'(e_addr));
      if (e_rv != '0) chk("model_rd_data", 32'(rd_data), 32'(mem[m_pend_addr]));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; req = '0; lock = '0;
    next();
    chk_en = 1'b1;
    next();
    rst = 1'b0;
  endtask

  logic [1:0] t1_gnt [4] = '{2'b00, 2'b01, 2'b00, 2'b10};
  logic [1:0] t1_rv  [4] = '{2'b00, 2'b00, 2'b01, 2'b00};
  logic [1:0] t3_gnt [8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
  logic [7:0] cat    [5] = '{8'h63, 8'h61, 8'h74, 8'h00, 8'h78};

  initial begin
    int pulses, beats0;
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h40 + i);
    mem[0] = 8'h63; mem[1] = 8'h61; mem[2] = 8'h74; mem[3] = 8'h00; mem[4] = 8'h78;
    req_addr = '0;

    // Reset, then both request with no lock
    reset_dut();
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_rd_valid", 32'(rd_valid), 32'h0);
    req = 2'b11; lock = 2'b00;
    req_addr[0*AW +: AW] = 4'd5; req_addr[1*AW +: AW] = 4'd6;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("t1_gnt_c%0d", c), 32'(gnt), 32'(t1_gnt[c]));
      chk($sformatf("t1_rv_c%0d", c), 32'(rd_valid), 32'(t1_rv[c]));
      next();
    end

    // Requester 1 locked burst walking "cat\0x"
    reset_dut();
    req = 2'b10; lock = 2'b10;
    next();
    for (int b = 0; b <= 5; b++) begin
      req = 2'b11;
      lock = (b < 4) ? 2'b10 : 2'b00;
      req_addr[1*AW +: AW] = 4'(b);
      @(negedge clk);
      if (b < 5) begin
        chk($sformatf("t2_gnt_b%0d", b), 32'(gnt), 32'h2);
        chk($sformatf("t2_addr_b%0d", b), 32'(sram_addr), 32'(b));
      end else begin
        chk("t2_gnt_release", 32'(gnt), 32'h0);
      end
      if (b > 0) begin
        chk($sformatf("t2_rv_b%0d", b), 32'(rd_valid), 32'h2);
        chk($sformatf("t2_data_b%0d", b), 32'(rd_data), 32'(cat[b-1]));
      end
      next();
    end
    @(negedge clk);
    chk("t2_req0_next", 32'(gnt), 32'h1);
    next();

    // Continuous requests without lock alternate with one IDLE gap
    reset_dut();
    req = 2'b11; lock = 2'b00;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("t3_gnt_c%0d", c), 32'(gnt), 32'(t3_gnt[c]));
      next();
    end

    // Owner drops req after two beats
    reset_dut();
    pulses = 0;
    lock = 2'b01;
    for (int c = 0; c < 7; c++) begin
      req = (c < 3) ? 2'b01 : 2'b00;
      @(negedge clk);
      if (rd_valid[0]) pulses++;
      if (c == 3) begin
        chk("t4_cs_drop", 32'(sram_cs), 32'h0);
        chk("t4_gnt_hold", 32'(gnt), 32'h1);
      end
      if (c == 4) chk("t4_gnt_gone", 32'(gnt), 32'h0);
      next();
    end
    chk("t4_pulses", 32'(pulses), 32'd2);

    // Reset on the cycle after a beat
    reset_dut();
    req = 2'b01; lock = 2'b01;
    next();
    @(negedge clk);
    chk("t5_beat_cs", 32'(sram_cs), 32'h1);
    next();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rv_killed", 32'(rd_valid), 32'h0);
    chk("t5_cs_killed", 32'(sram_cs), 32'h0);
    next();
    rst = 1'b0; req = 2'b11; lock = 2'b00;
    @(negedge clk);
    chk("t5_gnt_after_rst", 32'(gnt), 32'h0);
    next();
    @(negedge clk);
    chk("t5_req0_wins", 32'(gnt), 32'h1);
    next();

    // Locked requester 0 against waiting requester 1
    reset_dut();
    beats0 = 0;
    req = 2'b11; lock = 2'b01;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (gnt == 2'b01 && sram_cs) beats0++;
`ifdef VOCAB_PORT_ARBITER_BURST_LIMIT_EN
      if (c == 6) chk("t6_gnt_c6", 32'(gnt), 32'h2);
`else
      if (c == 6) chk("t6_gnt_c6", 32'(gnt), 32'h1);
`endif
      next();
    end
`ifdef VOCAB_PORT_ARBITER_BURST_LIMIT_EN
    chk("t6_beats", 32'(beats0), 32'd4);
`else
    chk("t6_beats", 32'(beats0), 32'd7);
`endif

    // Mixed traffic, model-checked only
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      req      = N'($urandom_range(0, 3));
      lock     = N'($urandom_range(0, 3));
      req_addr = (N*AW)'($urandom);
      rst      = ($urandom_range(0, 39) == 0);
      next();
    end
    rst = 1'b0; req = '0; lock = '0;
    next();
    next();
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
